// File: rtl/serial_msg_pkg.sv
// Shared types, character constants and round-robin helpers for the serial
// message arbiter.
//   state_t        : arbiter FSM states
//   CHAR_*         : control characters used on the byte stream
//   rr_pick()      : one-hot round-robin grant, first request after `last`
//   onehot_to_idx(): index of the set bit in a one-hot vector
package serial_msg_pkg;

   localparam int unsigned MAX_REQ = 4;
   localparam int unsigned MAX_IDX_W = 2;

   localparam logic [7:0] CHAR_CR  = 8'h0D;
   localparam logic [7:0] CHAR_LF  = 8'h0A;
   localparam logic [7:0] CHAR_NUL = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_SEND,
      ST_WAIT_BUSY,
      ST_WAIT_IDLE,
      ST_CRLF,
      ST_FINISH
   } state_t;

   // Scan (last+1) .. (last+n) modulo n and grant the first active request.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                  input logic [MAX_IDX_W-1:0] last,
                                                  input int unsigned          n);
      logic [MAX_REQ-1:0] g;
      int unsigned idx;
      g = '0;
      for (int unsigned k = 1; k <= n; k++) begin
         idx = (32'(last) + k) % n;
         if (g == '0 && req[idx[MAX_IDX_W-1:0]]) begin
            g[idx[MAX_IDX_W-1:0]] = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(MAX_REQ); i++) begin
         if (oh[i]) begin
            idx = MAX_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/serial_msg_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational pick plus a registered pointer to the
// last requester served.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector
//   update     : load the pointer from grant_upd (one cycle)
//   grant_upd  : one-hot grant that just completed
//   pick_c     : one-hot choice for the next grant (combinational)
module rr_arbiter
   import serial_msg_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               update,
   input  logic [NUM_REQ-1:0] grant_upd,
   output logic [NUM_REQ-1:0] pick_c
);

   logic [MAX_IDX_W-1:0] last_idx;

   // Pointer starts at the top requester so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_idx <= MAX_IDX_W'(NUM_REQ - 1);
      end else if (update) begin
         last_idx <= onehot_to_idx(MAX_REQ'(grant_upd));
      end
   end

   assign pick_c = NUM_REQ'(rr_pick(MAX_REQ'(req), last_idx, NUM_REQ));

endmodule

// File: rtl/serial_msg_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ message sources. Grants one
// requester round-robin, latches its CHARS-byte string, streams the non-NUL
// bytes (optionally followed by CR LF) and pulses that requester's done.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-requester level request, held until done
//   msg_flat   : requester i string at [i*8*CHARS +: 8*CHARS], first char MS byte
//   done       : one-cycle completion pulse to the finished requester
//   grant      : one-hot current owner, 0 when idle
//   tx_send    : one-cycle strobe, tx_data valid
//   tx_data    : byte to transmit
//   tx_busy    : transmitter busy
module serial_msg_arbiter
   import serial_msg_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned CHARS       = 16,
   parameter bit          APPEND_CRLF = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*8*CHARS-1:0] msg_flat,
   output logic [NUM_REQ-1:0]         done,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       tx_send,
   output logic [7:0]                 tx_data,
   input  logic                       tx_busy
);

   localparam int unsigned MSG_W = 8 * CHARS;
   localparam int unsigned CNT_W = $clog2(CHARS + 1);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_t                 state;
   logic [MSG_W-1:0]       shreg;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       gidx;
   logic                   in_crlf;
   logic                   crlf_idx;
   logic                   holdoff;

   logic [NUM_REQ-1:0]     pick_c;
   logic                   arb_update_c;
   logic [7:0]             top_byte_c;
   logic [7:0]             cur_byte_c;
   logic                   cnt_last_c;
   logic [MSG_W-1:0]       msgs_c [NUM_REQ];

   for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_slice
      assign msgs_c[i] = msg_flat[i*MSG_W +: MSG_W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .update    (arb_update_c),
      .grant_upd (grant),
      .pick_c    (pick_c)
   );

   assign arb_update_c = (state == ST_FINISH);
   assign top_byte_c   = shreg[MSG_W-1 -: 8];
   assign cur_byte_c   = in_crlf ? (crlf_idx ? CHAR_LF : CHAR_CR) : top_byte_c;
   // Next shift consumes the final character slot.
   assign cnt_last_c   = (cnt == CNT_W'(CHARS - 1));

   // Message sequencer; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         grant    <= '0;
         done     <= '0;
         tx_send  <= 1'b0;
         tx_data  <= '0;
         shreg    <= '0;
         cnt      <= '0;
         gidx     <= '0;
         in_crlf  <= 1'b0;
         crlf_idx <= 1'b0;
         holdoff  <= 1'b0;
      end else begin
         done    <= '0;
         tx_send <= 1'b0;
         case (state)
            ST_IDLE: begin
               // One dead cycle after done keeps a requester that has not yet
               // dropped req from being re-granted immediately.
               if (holdoff) begin
                  holdoff <= 1'b0;
               end else if (|req) begin
                  grant <= pick_c;
                  gidx  <= IDX_W'(onehot_to_idx(MAX_REQ'(pick_c)));
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               shreg    <= msgs_c[gidx];
               cnt      <= '0;
               in_crlf  <= 1'b0;
               crlf_idx <= 1'b0;
               state    <= ST_CHECK;
            end
            ST_CHECK: begin
               if (top_byte_c == CHAR_NUL) begin
                  shreg <= {shreg[MSG_W-9:0], 8'h00};
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt_last_c) begin
                     if (APPEND_CRLF) state <= ST_CRLF;
                     else             state <= ST_FINISH;
                  end
               end else begin
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  tx_send <= 1'b1;
                  tx_data <= cur_byte_c;
                  state   <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (tx_busy) state <= ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
               if (!tx_busy) begin
                  if (in_crlf) begin
                     if (crlf_idx) begin
                        state <= ST_FINISH;
                     end else begin
                        crlf_idx <= 1'b1;
                        state    <= ST_CRLF;
                     end
                  end else begin
                     shreg <= {shreg[MSG_W-9:0], 8'h00};
                     cnt   <= cnt + CNT_W'(1);
                     if (cnt_last_c) begin
                        if (APPEND_CRLF) state <= ST_CRLF;
                        else             state <= ST_FINISH;
                     end else begin
                        state <= ST_CHECK;
                     end
                  end
               end
            end
            ST_CRLF: begin
               in_crlf <= 1'b1;
               state   <= ST_SEND;
            end
            ST_FINISH: begin
               done    <= grant;
               grant   <= '0;
               holdoff <= 1'b1;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_msg_arbiter.sv
// Directed bench for serial_msg_arbiter with a behavioural UART tx model.
module tb_serial_msg_arbiter;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned CHARS   = 16;
   localparam int unsigned MSG_W   = 8 * CHARS;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic [NUM_REQ-1:0]         req = '0;
   logic [NUM_REQ*MSG_W-1:0]   msg_flat = '0;
   logic [NUM_REQ-1:0]         done;
   logic [NUM_REQ-1:0]         grant;
   logic                       tx_send;
   logic [7:0]                 tx_data;
   logic                       tx_busy;

   logic model_busy = 1'b0;
   int   busy_cnt = 0;
   logic ext_busy = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [7:0]         byte_q [$];
   logic [NUM_REQ-1:0] grant_q [$];
   int                 done_cnt [NUM_REQ];
   int                 viol = 0;
   logic               prev_send = 1'b0;
   logic [NUM_REQ-1:0] prev_grant = '0;

   logic [127:0] m_code = "CODEBREAKER DONE";
   logic [127:0] m_key  = {"KEY", 104'h0};
   logic [127:0] m_a    = {"A", 120'h0};
   logic [127:0] m_b    = {"B", 120'h0};
   logic [127:0] m_zzz  = {16{8'h5A}};

   logic [7:0] exp_code [$] = '{8'h43, 8'h4F, 8'h44, 8'h45, 8'h42, 8'h52, 8'h45, 8'h41,
                                8'h4B, 8'h45, 8'h52, 8'h20, 8'h44, 8'h4F, 8'h4E, 8'h45,
                                8'h0D, 8'h0A};
   logic [7:0] exp_key [$]  = '{8'h4B, 8'h45, 8'h59, 8'h0D, 8'h0A};

   assign tx_busy = model_busy | ext_busy;

   always #5 clk = ~clk;

   serial_msg_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .CHARS       (CHARS),
      .APPEND_CRLF (1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .msg_flat (msg_flat),
      .done     (done),
      .grant    (grant),
      .tx_send  (tx_send),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy)
   );

   // UART model: busy from the cycle after tx_send for 10 cycles.
   always @(posedge clk) begin
      if (tx_send) begin
         model_busy <= 1'b1;
         busy_cnt   <= 10;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else if (busy_cnt == 1) begin
         busy_cnt   <= 0;
         model_busy <= 1'b0;
      end
   end

   // Monitor: byte log, grant order, done pulses, tx_send protocol.
   always @(posedge clk) begin
      if (tx_send) byte_q.push_back(tx_data);
      if (tx_send && (tx_busy || prev_send)) viol++;
      prev_send = tx_send;
      if (grant != '0 && grant != prev_grant) grant_q.push_back(grant);
      prev_grant = grant;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (done[i]) done_cnt[i]++;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int r, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done[r]) begin
            seen = 1'b1;
            break;
         end
      end
      chk_eq($sformatf("done%0d_seen", r), 32'(seen), 32'd1);
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] exp [$]);
      chk_eq({tag, "_len"}, 32'(byte_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < byte_q.size(); i++) begin
         chk_eq($sformatf("%s_b%0d", tag, i), 32'(byte_q[i]), 32'(exp[i]));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit hit;
      for (int i = 0; i < int'(NUM_REQ); i++) done_cnt[i] = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_eq("rst_grant", 32'(grant), 32'd0);
      chk_eq("rst_done", 32'(done), 32'd0);
      chk_eq("rst_tx_send", 32'(tx_send), 32'd0);
      chk_eq("rst_tx_data", 32'(tx_data), 32'd0);
      reset = 1'b0;

      // Single full message with CR LF
      byte_q.delete();
      msg_flat = {m_b, m_code};
      req = 2'b01;
      wait_done(0, 3000);
      req = 2'b00;
      repeat (3) @(negedge clk);
      check_bytes("code", exp_code);
      chk_eq("code_done0_cnt", 32'(done_cnt[0]), 32'd1);
      chk_eq("code_done1_cnt", 32'(done_cnt[1]), 32'd0);
      chk_eq("code_grant_idle", 32'(grant), 32'd0);

      // NUL padding skipped
      byte_q.delete();
      msg_flat = {m_b, m_key};
      req = 2'b01;
      wait_done(0, 3000);
      chk_eq("key_busy_at_done", 32'(tx_busy), 32'd0);
      req = 2'b00;
      repeat (3) @(negedge clk);
      check_bytes("key", exp_key);

      // Simultaneous requests, round robin
      do_reset();
      grant_q.delete();
      msg_flat = {m_b, m_a};
      req = 2'b11;
      base = 0;
      for (int i = 0; i < 4000 && base < 4; i++) begin
         @(negedge clk);
         if (|done) base++;
      end
      req = 2'b00;
      repeat (5) @(negedge clk);
      chk_eq("rr_msgs", 32'(base), 32'd4);
      chk_eq("rr_len", 32'(grant_q.size()), 32'd4);
      if (grant_q.size() == 4) begin
         chk_eq("rr_g0", 32'(grant_q[0]), 32'd1);
         chk_eq("rr_g1", 32'(grant_q[1]), 32'd2);
         chk_eq("rr_g2", 32'(grant_q[2]), 32'd1);
         chk_eq("rr_g3", 32'(grant_q[3]), 32'd2);
      end

      // Reset mid-stream
      byte_q.delete();
      msg_flat = {m_b, m_code};
      req = 2'b01;
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (byte_q.size() >= 5) begin
            hit = 1'b1;
            break;
         end
      end
      chk_eq("mid_reached5", 32'(hit), 32'd1);
      base = done_cnt[0];
      reset = 1'b1;
      @(negedge clk);
      chk_eq("mid_grant", 32'(grant), 32'd0);
      chk_eq("mid_tx_send", 32'(tx_send), 32'd0);
      chk_eq("mid_done", 32'(done), 32'd0);
      byte_q.delete();
      reset = 1'b0;
      wait_done(0, 3000);
      req = 2'b00;
      repeat (3) @(negedge clk);
      chk_eq("mid_done_cnt", 32'(done_cnt[0]), 32'(base + 1));
      check_bytes("restart", exp_code);

      // Backpressure from the transmitter
      byte_q.delete();
      ext_busy = 1'b1;
      msg_flat = {m_b, m_key};
      req = 2'b01;
      repeat (40) @(negedge clk);
      chk_eq("bp_no_bytes", 32'(byte_q.size()), 32'd0);
      chk_eq("bp_tx_send", 32'(tx_send), 32'd0);
      chk_eq("bp_grant", 32'(grant), 32'd1);
      ext_busy = 1'b0;
      wait_done(0, 3000);
      req = 2'b00;
      repeat (3) @(negedge clk);
      check_bytes("bp", exp_key);

      // Request dropped and message changed after load
      byte_q.delete();
      msg_flat = {m_b, m_key};
      req = 2'b01;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (grant[0]) begin
            hit = 1'b1;
            break;
         end
      end
      chk_eq("drop_granted", 32'(hit), 32'd1);
      @(negedge clk);
      req = 2'b00;
      msg_flat = {m_zzz, m_zzz};
      wait_done(0, 3000);
      repeat (3) @(negedge clk);
      check_bytes("drop", exp_key);

      chk_eq("tx_protocol", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
